result_reader: RTL and testbench
================================

Name: result_reader

Overview:
- Drains the result memory that the systolic array fills through its write port (ws/we/sum_out) after sys_finish.
- On sys_finish, reads NUM_WORDS bytes from BASE_ADDR upward over a synchronous one-cycle-latency read port.
- Presents each byte to the UART transmitter on a valid/ready byte stream.
- Sits between the result RAM read port and the UART TX front end.

Parameters:
- ADDR_W, 14, memory address width; matches the systolic write address ws.
- DATA_W, 8, data width; matches sum_out.
- BASE_ADDR, 0, first address read.
- NUM_WORDS, 64, bytes per drain, range 1..2**ADDR_W.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- sys_finish  in  1  completion pulse from the systolic array; level-sampled.
- rs  out  ADDR_W  read address to the result RAM.
- re  out  1  read enable to the result RAM.
- rd_data  in  DATA_W  RAM read data, valid the cycle after re.
- tx_data  out  DATA_W  byte to the UART transmitter.
- tx_valid  out  1  tx_data valid.
- tx_ready  in  1  transmitter accepts the byte.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse after the final byte is accepted.

Behaviour:
- Reset: one clock and a synchronous active-low reset. rst_n low at a clk edge forces:
  - state to IDLE;
  - rs=0, re=0, tx_data=0, tx_valid=0, busy=0, done=0;
  - the word counter to 0.
- Reset takes priority over every other event, including mid-drain and during tx_valid.
- A drain aborted by reset is not resumed.
- FSM states: IDLE, READ, CAPTURE, SEND, DONE.
- IDLE: sys_finish high moves to READ and loads addr=BASE_ADDR, cnt=0. Otherwise stays in IDLE.
- READ, one cycle: re=1, rs=addr. Goes to CAPTURE.
- CAPTURE, one cycle: tx_data <= rd_data and tx_valid <= 1. Goes to SEND.
- SEND:
  - tx_valid and tx_data hold stable until a cycle with tx_ready=1.
  - On that handshake, tx_valid <= 0.
  - If cnt==NUM_WORDS-1, go to DONE. Otherwise addr <= addr+1, cnt <= cnt+1, go to READ.
- DONE, one cycle: done=1. Goes to IDLE.
- Latency:
  - sys_finish sampled at edge T gives re=1 during cycle T+1.
  - tx_valid rises at T+3.
  - Per-byte cost is 3 cycles plus the tx_ready wait.
- tx_ready high before tx_valid has no effect. tx_ready is only evaluated in SEND.
- sys_finish while busy is ignored and not queued.
- Address arithmetic wraps modulo 2**ADDR_W. BASE_ADDR+NUM_WORDS beyond the top reads wrapped addresses.
- re is high only in READ. rs holds its last value otherwise.

Optional Feature:
- Macro: RESULT_READER_CHECKSUM_EN.
- When defined:
  - An 8-bit accumulator clears on leaving IDLE.
  - It adds each accepted byte modulo 256.
  - After the last data byte, an extra state CSUM presents tx_data=accumulator, tx_valid=1, with the same handshake as SEND.
  - DONE follows CSUM's handshake.
  - The stream is NUM_WORDS+1 bytes, with no RAM read for the checksum.
- When undefined: no accumulator, no CSUM state, stream is exactly NUM_WORDS bytes.

Decomposition:
- Shared package systolic_pkg holds:
  - ADDR_W=14 and DATA_W=8 constants, shared with the systolic array and the result RAM;
  - the result_reader state enum typedef.
- No sub-module. FSM, address counter and optional accumulator stay in one module of roughly 150-250 lines.

Test Plan:
- Reset mid-SEND: NUM_WORDS=4, tx_ready tied low, rst_n pulled low while tx_valid=1.
  - Next edge: tx_valid=0, busy=0, state IDLE.
  - A later sys_finish restarts from addr 0.
- Basic drain: RAM[0..3]=8'h11,22,33,44, NUM_WORDS=4, tx_ready=1, sys_finish pulse at T.
  - re at T+1 with rs=0.
  - tx_valid at T+3 with 8'h11.
  - Bytes 11,22,33,44 in order.
  - done pulses once, one cycle after the 8'h44 handshake.
- Backpressure: tx_ready low 10 cycles per byte.
  - tx_data stays stable while tx_valid is high.
  - No re pulses during the wait.
  - The byte sequence is unchanged.
- Ignored restart: sys_finish pulsed again during byte 2.
  - Exactly 4 bytes sent and one done pulse.
  - busy drops only after DONE.
- Wrap: BASE_ADDR=14'h3FFE, NUM_WORDS=4 → rs sequence 3FFE, 3FFF, 0000, 0001.
- Checksum (RESULT_READER_CHECKSUM_EN): bytes 8'hF0, 8'h20, 8'h05 → fourth byte 8'h15; done follows it.

Source files
------------

// File: rtl/systolic_pkg.sv
// Constants shared by the systolic array, result RAM and result reader.
// RESULT_READER_CHECKSUM_EN adds the CSUM state to the reader FSM.
package systolic_pkg;

  localparam int ADDR_W = 14;
  localparam int DATA_W = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_CAPTURE,
    S_SEND,
`ifdef RESULT_READER_CHECKSUM_EN
    S_CSUM,
`endif
    S_DONE
  } rr_state_e;

endpackage

// File: rtl/result_reader_if.sv
// Result RAM read port plus UART TX byte stream.
// master = result_reader, slave = RAM/UART side.
interface result_reader_if #(
  parameter int ADDR_W = systolic_pkg::ADDR_W,
  parameter int DATA_W = systolic_pkg::DATA_W
);

  logic [ADDR_W-1:0] rs;
  logic              re;
  logic [DATA_W-1:0] rd_data;
  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_ready;

  modport master (
    output rs, re, tx_data, tx_valid,
    input  rd_data, tx_ready
  );

  modport slave (
    input  rs, re, tx_data, tx_valid,
    output rd_data, tx_ready
  );

endinterface

// File: rtl/result_reader.sv
// Drains NUM_WORDS result bytes from RAM to the UART TX stream.
// RESULT_READER_CHECKSUM_EN appends a mod-256 checksum byte.
module result_reader #(
  parameter int ADDR_W = systolic_pkg::ADDR_W,
  parameter int DATA_W = systolic_pkg::DATA_W,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int NUM_WORDS = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            sys_finish,
  result_reader_if.master bus,
  output logic            busy,
  output logic            done
);

  import systolic_pkg::*;

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NUM_WORDS - 1);

  rr_state_e         state_q;
  logic [ADDR_W-1:0] rs_q;
  logic [ADDR_W-1:0] cnt_q;
  logic              re_q;
  logic [DATA_W-1:0] tx_data_q;
  logic              tx_valid_q;
  logic              busy_q;
  logic              done_q;
  logic              last;
`ifdef RESULT_READER_CHECKSUM_EN
  logic [7:0]        acc_q;
`endif

  assign last = (cnt_q == LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      rs_q       <= '0;
      cnt_q      <= '0;
      re_q       <= 1'b0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
`ifdef RESULT_READER_CHECKSUM_EN
      acc_q      <= '0;
`endif
    end else begin
      re_q   <= 1'b0;
      done_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (sys_finish) begin
            state_q <= S_READ;
            rs_q    <= BASE_ADDR;
            cnt_q   <= '0;
            re_q    <= 1'b1;
            busy_q  <= 1'b1;
`ifdef RESULT_READER_CHECKSUM_EN
            acc_q   <= '0;
`endif
          end
        end
        S_READ: begin
          state_q <= S_CAPTURE;
        end
        S_CAPTURE: begin
          tx_data_q  <= bus.rd_data;
          tx_valid_q <= 1'b1;
          state_q    <= S_SEND;
        end
        S_SEND: begin
          if (bus.tx_ready) begin
            tx_valid_q <= 1'b0;
`ifdef RESULT_READER_CHECKSUM_EN
            acc_q      <= acc_q + 8'(tx_data_q);
`endif
            if (last) begin
`ifdef RESULT_READER_CHECKSUM_EN
              // checksum includes the byte being accepted now
              tx_data_q  <= DATA_W'(acc_q + 8'(tx_data_q));
              tx_valid_q <= 1'b1;
              state_q    <= S_CSUM;
`else
              done_q     <= 1'b1;
              state_q    <= S_DONE;
`endif
            end else begin
              rs_q    <= rs_q + 1'b1;
              cnt_q   <= cnt_q + 1'b1;
              re_q    <= 1'b1;
              state_q <= S_READ;
            end
          end
        end
`ifdef RESULT_READER_CHECKSUM_EN
        S_CSUM: begin
          if (bus.tx_ready) begin
            tx_valid_q <= 1'b0;
            done_q     <= 1'b1;
            state_q    <= S_DONE;
          end
        end
`endif
        S_DONE: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.rs       = rs_q;
  assign bus.re       = re_q;
  assign bus.tx_data  = tx_data_q;
  assign bus.tx_valid = tx_valid_q;
  assign busy         = busy_q;
  assign done         = done_q;

endmodule

// File: tb/tb_result_reader.sv
// Bench for result_reader: two instances (base 0 and wrapping base 3FFE)
// share one RAM model, tx_ready and sys_finish, compared to a stream model.
module tb_result_reader;

  logic clk = 1'b0;
  logic rst_n;
  logic sys_finish;
  logic tx_ready;
  logic busy0, busy1, done0, done1;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  result_reader_if #(.ADDR_W(14), .DATA_W(8)) i0 ();
  result_reader_if #(.ADDR_W(14), .DATA_W(8)) i1 ();

  result_reader #(.BASE_ADDR(14'h0000), .NUM_WORDS(4)) u0 (
    .clk(clk), .rst_n(rst_n), .sys_finish(sys_finish),
    .bus(i0.master), .busy(busy0), .done(done0)
  );

  result_reader #(.BASE_ADDR(14'h3FFE), .NUM_WORDS(4)) u1 (
    .clk(clk), .rst_n(rst_n), .sys_finish(sys_finish),
    .bus(i1.master), .busy(busy1), .done(done1)
  );

  logic [7:0] mem [0:16383];

  always @(posedge clk) begin
    if (i0.re) i0.rd_data <= mem[i0.rs];
    if (i1.re) i1.rd_data <= mem[i1.rs];
  end

  assign i0.tx_ready = tx_ready;
  assign i1.tx_ready = tx_ready;

  logic [1:0]  tv, re_s, bz, dn;
  logic [7:0]  td   [2];
  logic [13:0] rs_s [2];
  assign tv   = {i1.tx_valid, i0.tx_valid};
  assign re_s = {i1.re, i0.re};
  assign bz   = {busy1, busy0};
  assign dn   = {done1, done0};
  assign td[0] = i0.tx_data;
  assign td[1] = i1.tx_data;
  assign rs_s[0] = i0.rs;
  assign rs_s[1] = i1.rs;

`ifdef RESULT_READER_CHECKSUM_EN
  localparam int NB = 5;
`else
  localparam int NB = 4;
`endif

  int         base_a [2] = '{0, 16382};
  logic [13:0] exp_a [2][4];
  logic [7:0]  exp_b [2][5];

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic build_model();
    for (int k = 0; k < 2; k++) begin
      int sum = 0;
      for (int i = 0; i < 4; i++) begin
        int a = (base_a[k] + i) % 16384;
        exp_a[k][i] = 14'(a);
        exp_b[k][i] = mem[a];
        sum += mem[a];
      end
      exp_b[k][4] = 8'(sum % 256);
    end
  endtask

  // bp: 0 = always ready, 1 = 10-cycle stall per byte, 2 = random stall
  task automatic drain(input int bp, input bit restart);
    int j = 0, idx = 0, rdn = 0, wcnt = 0, rw = 0;
    int ndone = 0, last_hs = -10;
    bit fin = 0, rst_pulsed = 0, pv = 0, prdy = 0;
    logic [7:0] pd [2];
    build_model();
    sys_finish = 1'b1;
    @(negedge clk);
    sys_finish = 1'b0;
    while (j < 600 && !fin) begin
      if (j == 0) begin
        chk("re_at_T1", 32'(re_s[0]), 1);
        chk("rs_at_T1", 32'(rs_s[0]), 32'(exp_a[0][0]));
      end
      if (j == 1) chk("valid_low_T2", 32'(tv[0]), 0);
      if (j == 2) chk("valid_at_T3", 32'(tv[0]), 1);
      if (rst_pulsed && sys_finish) sys_finish = 1'b0;
      for (int k = 0; k < 2; k++) begin
        if (re_s[k]) begin
          chk("rs_seq", 32'(rs_s[k]), 32'(exp_a[k][rdn % 4]));
          chk("re_while_valid", 32'(tv[k]), 0);
        end
        if (pv && !prdy) begin
          chk("valid_hold", 32'(tv[k]), 1);
          chk("data_hold", 32'(td[k]), 32'(pd[k]));
        end
      end
      if (re_s[0]) rdn++;
      if (ndone > 0 && !dn[0]) begin
        chk("busy_after_done", 32'(bz), 0);
        fin = 1;
      end else begin
        chk("busy_while_draining", 32'(bz), 3);
      end
      if (dn[0]) begin
        ndone++;
        chk("done_bytes", idx, NB);
        chk("done_one_after_hs", j - last_hs, 1);
        chk("done_both", 32'(dn[1]), 1);
      end
      if (restart && !rst_pulsed && idx == 1 && tv[0]) begin
        sys_finish = 1'b1;
        rst_pulsed = 1;
      end
      if (tv[0]) begin
        case (bp)
          0:       tx_ready = 1'b1;
          1:       tx_ready = (wcnt >= 10);
          default: tx_ready = (wcnt >= rw);
        endcase
        if (!tx_ready) wcnt++;
      end else begin
        tx_ready = 1'($urandom % 2);
      end
      if (tv[0] && tx_ready) begin
        for (int k = 0; k < 2; k++)
          chk("byte", 32'(td[k]), 32'(exp_b[k][idx]));
        idx++;
        last_hs = j;
        wcnt = 0;
        rw = $urandom_range(0, 3);
      end
      pv = tv[0];
      prdy = tx_ready;
      pd = td;
      @(negedge clk);
      j++;
    end
    sys_finish = 1'b0;
    chk("drain_finished", 32'(fin), 1);
    chk("done_count", ndone, 1);
    chk("byte_count", idx, NB);
    chk("read_count", rdn, 4);
    for (int i = 0; i < 4; i++) begin
      tx_ready = 1'($urandom % 2);
      chk("idle_quiet", {28'd0, bz, re_s}, 0);
      @(negedge clk);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    sys_finish = 1'b0;
    tx_ready = 1'b0;
    for (int a = 0; a < 16384; a++) mem[a] = 8'($urandom);
    repeat (3) @(negedge clk);
    chk("rst_valid", 32'(tv), 0);
    chk("rst_re", 32'(re_s), 0);
    chk("rst_busy", 32'(bz), 0);
    chk("rst_done", 32'(dn), 0);
    chk("rst_rs", {4'd0, rs_s[1], rs_s[0]}, 0);
    chk("rst_data", {16'd0, td[1], td[0]}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    mem[0] = 8'h11; mem[1] = 8'h22; mem[2] = 8'h33; mem[3] = 8'h44;
    drain(0, 0);

    // reset while a byte is waiting for tx_ready
    tx_ready = 1'b0;
    sys_finish = 1'b1;
    @(negedge clk);
    sys_finish = 1'b0;
    for (int i = 0; i < 20 && !tv[0]; i++) @(negedge clk);
    chk("pre_reset_valid", 32'(tv), 3);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_valid", 32'(tv), 0);
    chk("mid_rst_busy", 32'(bz), 0);
    chk("mid_rst_done", 32'(dn), 0);
    chk("mid_rst_rs", {4'd0, rs_s[1], rs_s[0]}, 0);
    chk("mid_rst_data", {16'd0, td[1], td[0]}, 0);
    rst_n = 1'b1;
    tx_ready = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("no_resume", {28'd0, bz, tv}, 0);
    end
    drain(0, 0);

    for (int a = 0; a < 4; a++) mem[a] = 8'($urandom);
    drain(1, 0);

    mem[16382] = 8'($urandom);
    drain(2, 1);

    mem[0] = 8'hF0; mem[1] = 8'h20; mem[2] = 8'h05; mem[3] = 8'h00;
    drain(0, 0);

    repeat (4) begin
      for (int a = 0; a < 4; a++) begin
        mem[a] = 8'($urandom);
        mem[16382 + (a % 2)] = 8'($urandom);
      end
      drain(2, 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
